stream_arb_2to1: RTL

- Merge block for the routing fabric: combines two valid/ready word streams into one downstream stream, the converse of the 1-to-2 demux.
- Arbitrates per packet, round-robin. Once a port wins, it owns the output until its last beat, so packets are never interleaved.
- Output is registered. Throughput is one beat per cycle.
- Sits where two producers (e.g. two layer engines) share one consumer (accumulator or memory writer).

---
 rtl/routing_pkg.sv | 13 +
 rtl/stream_out_reg.sv | 43 ++++
 rtl/stream_arb_2to1.sv | 114 +++++++++++
 3 files changed

// File: rtl/routing_pkg.sv
// Shared definitions for the routing fabric stream blocks.
package routing_pkg;

  localparam int WORD_SIZE_DEF = 16;

  typedef logic port_id_t;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_t;

endpackage

// File: rtl/stream_out_reg.sv
// Registered output stage of a valid/ready stream with load-enable generation.
module stream_out_reg
  import routing_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [WORD_SIZE-1:0] load_data,
  input  logic                 load_last,
  input  port_id_t             load_src,
  input  logic                 out_ready,
  output logic                 load_ok,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_last,
  output port_id_t             out_src
);

  // Register may take a new beat when it is empty or its beat leaves this cycle.
  always_comb begin
    load_ok = !out_valid || out_ready;
  end

  // Capture a granted beat, drain on downstream accept, otherwise hold.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (load) begin
      out_data  <= load_data;
      out_valid <= 1'b1;
      out_last  <= load_last;
      out_src   <= load_src;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_arb_2to1.sv
// Packet-level round-robin merge of two valid/ready streams onto one registered output.
module stream_arb_2to1
  import routing_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] in0_data,
  input  logic                 in0_valid,
  input  logic                 in0_last,
  output logic                 in0_ready,
  input  logic [WORD_SIZE-1:0] in1_data,
  input  logic                 in1_valid,
  input  logic                 in1_last,
  output logic                 in1_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_last,
  output logic                 out_src,
  input  logic                 out_ready
);

  arb_state_t           state, state_nx;
  port_id_t             owner, owner_nx;
  port_id_t             rr_last, rr_last_nx;
  port_id_t             sel;
  logic                 grant;
  logic                 sel_valid;
  logic                 sel_last;
  logic [WORD_SIZE-1:0] sel_data;
  logic                 hs;
  logic                 load_ok;

  // Arbitration register; after reset port 1 counts as last served so port 0 wins first.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      owner   <= '0;
      rr_last <= 1'b1;
    end else begin
      state   <= state_nx;
      owner   <= owner_nx;
      rr_last <= rr_last_nx;
    end
  end

  // Grant selection, ready generation and packet-boundary transitions.
  always_comb begin
    state_nx   = state;
    owner_nx   = owner;
    rr_last_nx = rr_last;
    grant      = 1'b0;
    sel        = '0;

    case (state)
      IDLE: begin
        if (in0_valid && in1_valid) begin
          grant = 1'b1;
          sel   = ~rr_last;
        end else if (in0_valid) begin
          grant = 1'b1;
          sel   = 1'b0;
        end else if (in1_valid) begin
          grant = 1'b1;
          sel   = 1'b1;
        end
      end
      BUSY: begin
        grant = 1'b1;
        sel   = owner;
      end
      default: begin
        grant = 1'b0;
      end
    endcase

    sel_valid = sel ? in1_valid : in0_valid;
    sel_last  = sel ? in1_last  : in0_last;
    sel_data  = sel ? in1_data  : in0_data;

    in0_ready = reset_n && grant && !sel && load_ok;
    in1_ready = reset_n && grant &&  sel && load_ok;
    hs        = sel_valid && (sel ? in1_ready : in0_ready);

    if (hs) begin
      if (sel_last) begin
        state_nx   = IDLE;
        rr_last_nx = sel;
      end else begin
        state_nx = BUSY;
        owner_nx = sel;
      end
    end
  end

  stream_out_reg #(
    .WORD_SIZE (WORD_SIZE)
  ) u_out_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (hs),
    .load_data (sel_data),
    .load_last (sel_last),
    .load_src  (sel),
    .out_ready (out_ready),
    .load_ok   (load_ok),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_src   (out_src)
  );

endmodule
